prod_accum: RTL and testbench



---
 rtl/prod_accum_pkg.sv | 19 +
 rtl/prod_accum_if.sv | 31 +++
 rtl/prod_accum_add.sv | 34 +++
 rtl/prod_accum.sv | 80 ++++++++
 tb/tb_prod_accum.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg
// Shared definitions for the product accumulator: FSM state type, the
// product width delivered by the upstream 4x4 multiplier, and a helper
// for sizing the term counter.
package prod_accum_pkg;

    localparam int PROD_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Counter must be able to hold the value TERMS itself.
    function automatic int cnt_width(input int terms);
        return $clog2(terms + 1);
    endfunction

endpackage

// File: rtl/prod_accum_if.sv
// prod_accum_if
// Bundles the product input stream and the result output stream.
//   in_valid/in_ready/prod_in      : product stream into the accumulator
//   out_valid/out_ready            : result handshake
//   acc_out (ACC_W), out_ovf       : result payload
// slave  : accumulator side
// master : producer/consumer side (testbench or surrounding logic)
interface prod_accum_if #(
    parameter int ACC_W = 16
);
    import prod_accum_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] prod_in;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              out_ovf;

    modport master (
        output in_valid, prod_in, out_ready,
        input  in_ready, out_valid, acc_out, out_ovf
    );

    modport slave (
        input  in_valid, prod_in, out_ready,
        output in_ready, out_valid, acc_out, out_ovf
    );

endinterface

// File: rtl/prod_accum_add.sv
// prod_accum_add
// Combinational ACC_W-bit accumulate step: sum = acc + prod with carry-out.
//   acc   in  ACC_W   current accumulator value
//   prod  in  PROD_W  unsigned product
//   sum   out ACC_W   next accumulator value
//   carry out 1       carry out of the ACC_W-bit addition
// Build option PROD_ACCUM_SAT_EN: when defined, sum clamps to all-ones on
// carry instead of wrapping.
module prod_accum_add
    import prod_accum_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] full;

    always_comb begin
        full  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        carry = full[ACC_W];
`ifdef PROD_ACCUM_SAT_EN
        // Once clamped, acc is all-ones and any nonzero product carries
        // again, so the value stays pinned at the maximum.
        sum   = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
        sum   = full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/prod_accum.sv
// prod_accum
// Sums exactly TERMS unsigned 8-bit products from a valid/ready stream and
// presents the total on a valid/ready result handshake.
//   clk   in  1   rising-edge clock
//   rst   in  1   synchronous active-high reset
//   bus   slave modport of prod_accum_if (product in, result out)
// Parameters: TERMS (2..256) products per result, ACC_W (>=8) result width.
// Build option PROD_ACCUM_SAT_EN selects saturating instead of wrapping sums.
//
// state | meaning
// ACCUM | taking products, in_ready=1, out_valid=0
// HOLD  | result complete and frozen, in_ready=0, out_valid=1
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int TERMS = 8,
    parameter int ACC_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    prod_accum_if.slave  bus
);

    localparam int              CNT_W     = cnt_width(TERMS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERMS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             accept;
    logic             xfer;

    prod_accum_add #(.ACC_W(ACC_W)) u_add (
        .acc   (acc),
        .prod  (bus.prod_in),
        .sum   (sum),
        .carry (carry)
    );

    always_comb begin
        accept    = bus.in_valid  && (state == ACCUM);
        xfer      = bus.out_ready && (state == HOLD);
        state_nxt = state;
        case (state)
            ACCUM: if (accept && (cnt == CNT_LAST)) state_nxt = HOLD;
            HOLD:  if (xfer) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (accept) begin
                acc <= sum;
                cnt <= cnt + CNT_W'(1);
                ovf <= ovf | carry;
            end
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.acc_out   = acc;
    assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_prod_accum.sv
module tb_prod_accum;
    import prod_accum_pkg::*;

    localparam int TERMS_T = 4;
    localparam int ACC_W_T = 8;
    localparam longint MAXV = (64'd1 << ACC_W_T) - 1;

    logic clk;
    logic rst;

    prod_accum_if #(.ACC_W(ACC_W_T)) bus ();

    prod_accum #(.TERMS(TERMS_T), .ACC_W(ACC_W_T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint acc;
        longint ovf;
    } result_t;

    result_t exp_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      results_seen = 0;

    // reference model: count of products taken and their true total
    int      m_cnt   = 0;
    longint  m_total = 0;
    bit      armed   = 0;
    bit      post_rst = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic result_t expected_of(input longint total);
        result_t r;
        r.ovf = (total > MAXV) ? 1 : 0;
`ifdef PROD_ACCUM_SAT_EN
        r.acc = (total > MAXV) ? MAXV : total;
`else
        r.acc = total % (MAXV + 1);
`endif
        return r;
    endfunction

    // monitor: compares DUT outputs against the model, then advances the model
    always @(negedge clk) begin
        bit exp_hold;
        exp_hold = (m_cnt == TERMS_T);
        if (armed) begin
            check("in_ready", bus.in_ready, exp_hold ? 0 : 1);
            check("out_valid", bus.out_valid, exp_hold ? 1 : 0);
            if (post_rst) begin
                check("acc_out_after_rst", bus.acc_out, 0);
                check("out_ovf_after_rst", bus.out_ovf, 0);
            end
            if (exp_hold) begin
                if (exp_q.size() == 0) begin
                    check("result_queue_nonempty", 0, 1);
                end else begin
                    check("acc_out", bus.acc_out, exp_q[0].acc);
                    check("out_ovf", bus.out_ovf, exp_q[0].ovf);
                end
            end
        end
        if (rst) begin
            armed    = 1;
            post_rst = 1;
            m_cnt    = 0;
            m_total  = 0;
            exp_q.delete();
        end else begin
            post_rst = 0;
            if (armed) begin
                if (exp_hold) begin
                    if (bus.out_ready) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        results_seen++;
                        m_cnt   = 0;
                        m_total = 0;
                    end
                end else if (bus.in_valid) begin
                    m_total += longint'(bus.prod_in);
                    m_cnt++;
                    if (m_cnt == TERMS_T) exp_q.push_back(expected_of(m_total));
                end
            end
        end
    end

    task automatic step(input bit v, input int p, input bit r);
        bus.in_valid  = v;
        bus.prod_in   = 8'(p);
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int p0, input int p1, input int p2, input int p3, input bit r);
        step(1, p0, r);
        step(1, p1, r);
        step(1, p2, r);
        step(1, p3, r);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.prod_in   = '0;
        bus.out_ready = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1'b0;

        // basic sum, back-to-back transfer
        feed(10, 20, 30, 40, 1);
        step(0, 0, 1);
        step(0, 0, 1);

        // 225 x4 with random bubbles: overflows an 8-bit accumulator
        for (int i = 0; i < TERMS_T; i++) begin
            int nb;
            nb = $urandom_range(0, 2);
            for (int b = 0; b < nb; b++) step(0, $urandom_range(0, 255), 0);
            step(1, 225, 0);
        end
        step(0, 0, 1);

        // overflow early in the result, then small terms
        feed(200, 100, 1, 2, 1);
        step(0, 0, 1);

        // stall in HOLD with junk products presented
        feed(5, 6, 7, 8, 0);
        for (int i = 0; i < 5; i++) step(1, 99, 0);
        step(1, 99, 1);
        feed(1, 1, 1, 1, 1);
        step(0, 0, 1);

        // reset mid-accumulation
        step(1, 50, 1);
        step(1, 50, 1);
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        feed(1, 2, 3, 4, 1);
        step(0, 0, 1);

        // reset while a result is pending
        feed(9, 9, 9, 9, 0);
        step(0, 0, 0);
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        feed(0, 0, 0, 0, 1);
        step(0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int p;
            p = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : $urandom_range(0, 255);
            step($urandom_range(0, 3) != 0, p, $urandom_range(0, 2) != 0);
        end

        // drain
        for (int i = 0; i < 10; i++) step(0, 0, 1);
        @(negedge clk);
        check("queue_empty_at_end", exp_q.size(), 0);
        check("results_observed", (results_seen > 10) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
